// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: instruction step,
// target-select encoding and the jump-target concatenation helper.
package pc_pkg;

  localparam int INSTR_STEP = 4;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_REG
  } pc_sel_e;

  // Keeps the top high_w bits of seq and places idx just above the two zero
  // byte-offset bits; the caller truncates the result to its address width.
  function automatic logic [63:0] jump_concat(input logic [63:0] seq,
                                              input logic [63:0] idx,
                                              input int addr_w,
                                              input int high_w);
    int lo_w;
    logic [63:0] hi_part;
    lo_w    = addr_w - high_w;
    hi_part = (seq >> lo_w) << lo_w;
    return hi_part | (idx << 2);
  endfunction

endpackage

// File: rtl/pc_update_unit_link_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_link_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, pop_eff;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign pop_eff = pop && !empty;

  // ptr_q is the next free slot; a simultaneous pop+push rewrites the top in place.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = push;
    wr_idx  = ptr_q;
    if (pop_eff && push) begin
      wr_idx = top_idx;
    end else if (pop_eff) begin
      ptr_d   = top_idx;
      count_d = count_q - CNT_W'(1);
    end else if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_update_unit.sv
// Registered next-PC generator with sequential/branch/jump/register targets.
// Optional hardware link stack enabled by defining PC_RAS_EN.
module pc_update_unit
  import pc_pkg::*;
#(
  parameter int               ADDR_W       = 32,
  parameter int               HIGH_W       = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_offset,
  input  logic                       jump,
  input  logic [ADDR_W-HIGH_W-3:0]   jump_index,
  input  logic                       jump_reg,
  input  logic [ADDR_W-1:0]          reg_target,
  input  logic                       call,
  input  logic                       ret,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pc_next_seq,
  output logic [ADDR_W-1:0]          link_addr,
  output logic                       misalign_err,
  output logic                       ras_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              underflow_q, underflow_d;
  logic [ADDR_W-1:0] branch_tgt, jump_tgt, reg_src, reg_tgt;
  logic              ras_empty;
  pc_sel_e           sel;

  assign pc_next_seq = pc_q + ADDR_W'(INSTR_STEP);
  assign link_addr   = pc_next_seq;
  assign branch_tgt  = pc_next_seq + branch_offset;
  assign jump_tgt    = ADDR_W'(jump_concat(64'(pc_next_seq), 64'(jump_index), ADDR_W, HIGH_W));

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0]          ras_top;
  logic                       ras_full_unused;
  logic [$clog2(RAS_DEPTH):0] ras_count_unused;
  logic                       ras_push, ras_pop;

  // Calls only count when they actually redirect; a stalled cycle touches nothing.
  assign ras_push = !stall && call && (jump || jump_reg);
  assign ras_pop  = !stall && jump_reg && ret;

  pc_link_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_link_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused),
    .count     (ras_count_unused)
  );

  assign reg_src     = (jump_reg && ret && !ras_empty) ? ras_top : reg_target;
  assign underflow_d = !stall && jump_reg && ret && ras_empty;
`else
  logic call_ret_unused;
  assign call_ret_unused = call ^ ret;
  assign ras_empty       = 1'b1;
  assign reg_src         = reg_target;
  assign underflow_d     = 1'b0;
`endif

  assign reg_tgt    = {reg_src[ADDR_W-1:2], 2'b00};
  assign misalign_d = !stall && jump_reg && (reg_src[1:0] != 2'b00);

  always_comb begin
    sel = SEL_SEQ;
    if (jump_reg)          sel = SEL_REG;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;

    pc_d = pc_next_seq;
    case (sel)
      SEL_BRANCH: pc_d = branch_tgt;
      SEL_JUMP:   pc_d = jump_tgt;
      SEL_REG:    pc_d = reg_tgt;
      default:    pc_d = pc_next_seq;
    endcase
    if (stall) pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc            = pc_q;
  assign misalign_err  = misalign_q && !stall;
  assign ras_underflow = underflow_q && !stall;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed, table-driven bench for pc_update_unit (link-stack cases run
// when PC_RAS_EN is defined).
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 0, branch_taken = 0, jump = 0, jump_reg = 0, call = 0, ret = 0;
  logic [31:0] branch_offset = 0, reg_target = 0;
  logic [25:0] jump_index = 0;
  logic [31:0] pc, pc_next_seq, link_addr;
  logic        misalign_err, ras_underflow;

  int total = 0;
  int passed = 0;

  pc_update_unit #(.ADDR_W(32), .HIGH_W(4), .RESET_VECTOR(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .reg_target(reg_target), .call(call), .ret(ret),
    .pc(pc), .pc_next_seq(pc_next_seq), .link_addr(link_addr),
    .misalign_err(misalign_err), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic        stall, br, jmp, jr, cl;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jump_reg = 0; call = 0; ret = 0;
    branch_offset = 0; reg_target = 0; jump_index = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle();
    jump_reg = 1; reg_target = v;
    step();
    idle();
  endtask

  // Register jump that optionally pushes (call) and/or pops (ret).
  task automatic jr_op(input logic [31:0] tgt, input logic c, input logic r);
    idle();
    jump_reg = 1; reg_target = tgt; call = c; ret = r;
    step();
    idle();
  endtask

  initial begin
    vecs[0] = '{32'h3000_0000, 0, 1, 1, 0, 0, 32'h100,       26'h40,       0,            32'h3000_0100, 0};
    vecs[1] = '{32'h0000_0010, 0, 1, 0, 0, 0, 32'hFFFF_FFE0, 0,            0,            32'hFFFF_FFF4, 0};
    vecs[2] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0,             0,            0,            32'h0000_0000, 0};
    vecs[3] = '{32'h0000_0500, 0, 0, 0, 1, 0, 0,             0,            32'h2002,     32'h0000_2000, 1};
    vecs[4] = '{32'h0000_0500, 0, 1, 1, 1, 0, 32'h40,        26'h10,       32'h4000,     32'h0000_4000, 0};
    vecs[5] = '{32'h0000_0500, 1, 0, 1, 0, 0, 0,             26'h10,       0,            32'h0000_0500, 0};
    vecs[6] = '{32'h0000_0500, 1, 0, 0, 1, 0, 0,             0,            32'h2003,     32'h0000_0500, 0};
    vecs[7] = '{32'h7000_0000, 0, 0, 1, 0, 0, 0,             26'h3FF_FFFF, 0,            32'h7FFF_FFFC, 0};
    vecs[8] = '{32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0,             26'h10,       0,            32'h0000_0040, 0};
    vecs[9] = '{32'h0000_0200, 0, 0, 0, 0, 1, 0,             0,            0,            32'h0000_0204, 0};

    // Reset state and free-running sequence
    idle();
    rst = 1;
    step();
    chk("reset_pc", pc, 32'h100);
    chk("reset_mis", {31'b0, misalign_err}, 0);
    chk("reset_und", {31'b0, ras_underflow}, 0);
    chk("reset_seq", pc_next_seq, 32'h104);
    #2 rst = 0;
    step(); chk("free1", pc, 32'h104);
    step(); chk("free2", pc, 32'h108);
    step(); chk("free3", pc, 32'h10C);
    #3 rst = 1;
    #1 chk("midcycle_rst", pc, 32'h100);
    #2 rst = 0;
    $display("seq: reset and free-run done");

    for (int i = 0; i < 10; i++) begin
      set_pc(vecs[i].start_pc);
      stall = vecs[i].stall; branch_taken = vecs[i].br; jump = vecs[i].jmp;
      jump_reg = vecs[i].jr; call = vecs[i].cl; branch_offset = vecs[i].off;
      jump_index = vecs[i].idx; reg_target = vecs[i].rt;
      step();
      stall = 0;
      #1;
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_mis", i), {31'b0, misalign_err}, {31'b0, vecs[i].exp_mis});
      chk($sformatf("vec%0d_link", i), link_addr, vecs[i].exp_pc + 32'd4);
      $display("vec%0d: start=0x%08h pc=0x%08h mis=%0b", i, vecs[i].start_pc, pc, misalign_err);
      idle();
    end

    // Misaligned register jump then a stalled instruction
    set_pc(32'h500);
    jump_reg = 1; reg_target = 32'h2002;
    step();
    idle();
    chk("mis_pulse", {31'b0, misalign_err}, 1);
    chk("mis_pc", pc, 32'h2000);
    stall = 1;
    #1 chk("mis_forced_stall", {31'b0, misalign_err}, 0);
    step(); chk("stall1_pc", pc, 32'h2000);
    step(); chk("stall2_pc", pc, 32'h2000);
    chk("stall_mis", {31'b0, misalign_err}, 0);
    #2 rst = 1;
    #1 chk("rst_mid_stall", pc, 32'h100);
    #2 rst = 0;
    idle();
    step(); chk("after_stall_rst", pc, 32'h104);
    chk("after_stall_mis", {31'b0, misalign_err}, 0);
    $display("seq: misalign/stall done");

`ifdef PC_RAS_EN
    rst = 1; #2 rst = 0;
    set_pc(32'h10);
    for (int i = 1; i <= 5; i++) jr_op(32'h10 * (i + 1), 1, 0);
    chk("calls_pc", pc, 32'h60);
    jr_op(32'h900, 0, 1); chk("ret1", pc, 32'h54); chk("ret1_und", {31'b0, ras_underflow}, 0);
    jr_op(32'h900, 0, 1); chk("ret2", pc, 32'h44);
    jr_op(32'h900, 0, 1); chk("ret3", pc, 32'h34);
    jr_op(32'h900, 0, 1); chk("ret4", pc, 32'h24); chk("ret4_und", {31'b0, ras_underflow}, 0);
    jr_op(32'h900, 0, 1); chk("ret5", pc, 32'h900); chk("ret5_und", {31'b0, ras_underflow}, 1);
    step(); chk("und_one_cycle", {31'b0, ras_underflow}, 0);
    $display("seq: 5 calls / 5 rets done");

    rst = 1; #2 rst = 0;
    set_pc(32'h10);
    jr_op(32'h20, 1, 0);
    jr_op(32'h30, 1, 0);
    jr_op(32'h700, 1, 1);
    chk("callret_pc", pc, 32'h24);
    jr_op(32'h900, 0, 1); chk("callret_top", pc, 32'h34);
    jr_op(32'h900, 0, 1); chk("callret_next", pc, 32'h14);
    chk("callret_und0", {31'b0, ras_underflow}, 0);
    jr_op(32'h900, 0, 1); chk("callret_empty", pc, 32'h900);
    chk("callret_und1", {31'b0, ras_underflow}, 1);
    $display("seq: simultaneous call+ret done");
`else
    set_pc(32'h40);
    jr_op(32'h880, 1, 0);
    jr_op(32'h990, 0, 1);
    chk("noras_ret_pc", pc, 32'h990);
    chk("noras_und", {31'b0, ras_underflow}, 0);
    $display("seq: ret ignored without stack done");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Parametrised program-counter unit for the single-cycle RISC datapath, generalising the fixed 4-high/28-low jump-target concatenation into a registered next-PC generator. It holds the PC register and computes the sequential, branch, jump-concatenation and register targets. It applies a fixed priority and an optional hardware link stack, then updates the PC once per cycle unless stalled. It sits between the control unit and the instruction memory address port.

## Interface
Parameters:
- ADDR_W, 32, PC/address width in bits.
- HIGH_W, 4, upper PC bits retained in a jump target.
- RESET_VECTOR, 0, PC value loaded on reset; must be word-aligned.
- RAS_DEPTH, 4, link-stack entries; a power of two ≥ 2; used only with PC_RAS_EN.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and link stack this cycle.
- branch_taken  in  1  take the branch target.
- branch_offset  in  ADDR_W  sign-extended byte offset, already shifted left by 2.
- jump  in  1  take the concatenated jump target.
- jump_index  in  ADDR_W-HIGH_W-2  instruction jump field.
- jump_reg  in  1  take reg_target.
- reg_target  in  ADDR_W  register-sourced target.
- call  in  1  current jump/jump_reg is a call; push the link.
- ret  in  1  current jump_reg is a return; pop the link stack (PC_RAS_EN only).
- pc  out  ADDR_W  current PC, registered.
- pc_next_seq  out  ADDR_W  pc + 4, combinational.
- link_addr  out  ADDR_W  equals pc_next_seq; value written to the link register.
- misalign_err  out  1  registered one-cycle pulse for a reg_target with nonzero bits [1:0].
- ras_underflow  out  1  registered one-cycle pulse when a ret pops an empty stack.

## Operation
- Sequential target: pc + 4, modulo 2^ADDR_W. PC = 2^ADDR_W−4 wraps to 0.
- Branch target: pc_next_seq + branch_offset, modulo 2^ADDR_W. Overflow is ignored.
- Jump target: {pc_next_seq[ADDR_W-1:ADDR_W-HIGH_W], jump_index, 2'b00}.
- Register target: {reg_target[ADDR_W-1:2], 2'b00}. Nonzero low bits still take the masked target and set misalign_err for the next cycle.
- Priority (highest first): stall > jump_reg > jump > branch_taken > sequential.
- When jump_reg and ret are both set under PC_RAS_EN and the stack is not empty, the popped entry replaces reg_target.
- call without jump or jump_reg is ignored.
- misalign_err and ras_underflow are forced to 0 during stall.

## Timing
- Reset: pc = RESET_VECTOR, misalign_err = 0, ras_underflow = 0, link stack empty (count 0, pointer 0). Reset takes effect immediately and at any point, including mid-stall.
- Latency: the selected target appears on pc one cycle after the edge. pc_next_seq and link_addr are combinational from pc.
- Stall: pc, stack and pointers hold. Error outputs read 0.
- Error outputs are high for exactly one cycle per offending instruction.

## Configuration
- Macro: PC_RAS_EN.
- Defined: RAS_DEPTH-entry circular link stack.
  - call pushes link_addr. When full, the push overwrites the oldest entry and the count saturates at RAS_DEPTH.
  - ret with jump_reg pops the top entry and uses it as the target.
  - ret on an empty stack uses reg_target, pulses ras_underflow and leaves the count at 0.
  - call and ret in the same cycle: the pop is performed first, then the push. The net count is unchanged and the top entry becomes link_addr.
- Undefined: no stack storage, ret is ignored, ras_underflow is tied to 0.

## Structure
- Shared package pc_pkg:
  - INSTR_STEP = 4
  - the target-select enum {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_REG}
  - a function computing the jump concatenation for given ADDR_W/HIGH_W
- One sub-module, pc_link_stack: the circular buffer with push, pop, full/empty, count and top.
  - Instantiated only under PC_RAS_EN.

## Test plan
- Reset, then 3 free cycles with RESET_VECTOR=0x100 → pc = 0x100, 0x104, 0x108, 0x10C. Assert rst mid-cycle → pc is 0x100 immediately.
- pc=0x3000_0000, jump with jump_index=0x0000040 → next pc = 0x3000_0100. branch_taken in the same cycle is ignored.
- pc=0x0000_0010, branch_taken, branch_offset=0xFFFF_FFE0 → pc wraps to 0xFFFF_FFF4. Also pc=0xFFFF_FFFC sequential → pc = 0.
- jump_reg with reg_target=0x0000_2002 → pc = 0x0000_2000 and misalign_err high for one cycle. Asserting stall on the following instruction → pc holds for 2 cycles.
- PC_RAS_EN, RAS_DEPTH=4: 5 calls from pc = 0x10, 0x20, 0x30, 0x40, 0x50, then 5 rets.
  - The first 4 rets go to 0x54, 0x44, 0x34, 0x24.
  - The 5th ret takes reg_target and pulses ras_underflow.
- PC_RAS_EN, simultaneous call+ret with 2 entries stacked → target is the popped entry, the count stays 2, and the top entry equals link_addr.
